// File: rtl/nand_bist_driver.sv
// nand_bist_driver
//   On-chip stimulus driver and response checker for a bitwise-NAND block.
//   It sweeps every {A,B} operand pair. For each pair it drives the pair,
//   waits SETTLE_CYCLES cycles, samples Y and compares it with ~(A & B).
//   It reports busy/done/pass, a saturating mismatch count and the first
//   failing vector.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      starts a sweep; sampled only in IDLE and DONE
//   abort      in   1      any non-IDLE state -> IDLE; results are held
//   dut_a      out  W      operand A to the NAND block (registered)
//   dut_b      out  W      operand B to the NAND block (registered)
//   dut_y      in   W      response from the NAND block
//   busy       out  1      high while APPLY/SETTLE/CHECK
//   done       out  1      high in DONE
//   pass       out  1      1 when done and no mismatch was seen
//   err_count  out  ERR_W  mismatching vectors, saturating
//   fail_a     out  W      A of first mismatch (0 if none)
//   fail_b     out  W      B of first mismatch (0 if none)
//   fail_y     out  W      Y observed at first mismatch (0 if none)
module nand_bist_driver #(
  parameter int unsigned W             = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  input  logic [W-1:0]     dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [W-1:0]     fail_y
);

  localparam int unsigned VW = 2 * W;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  state_e           state_q;
  logic [VW-1:0]    vec_q;
  logic [SW-1:0]    settle_q;
  logic [W-1:0]     dut_a_q;
  logic [W-1:0]     dut_b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [W-1:0]     fail_a_q;
  logic [W-1:0]     fail_b_q;
  logic [W-1:0]     fail_y_q;

  logic [W-1:0]     expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_d;

  // The response is compared against the operands currently on the bus,
  // which are the ones applied for this vector.
  always_comb begin
    expected = ~(dut_a_q & dut_b_q);
    mismatch = (dut_y != expected);
    err_d    = err_q;
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      dut_a_q  <= '0;
      dut_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_y_q <= '0;
    end else if (abort && (state_q != IDLE)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= APPLY;
            vec_q    <= '0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            fail_y_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        APPLY: begin
          dut_a_q  <= vec_q[W-1:0];
          dut_b_q  <= vec_q[VW-1:W];
          settle_q <= '0;
          state_q  <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && (err_q == '0)) begin
            fail_a_q <= dut_a_q;
            fail_b_q <= dut_b_q;
            fail_y_q <= dut_y;
          end
          if (vec_q == '1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + VW'(1);
            state_q <= APPLY;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_y    = fail_y_q;

endmodule
